vga_timing_gen: RTL and testbench

Pixel-timing generator that produces the raster coordinates and sync/blank strobes consumed by the sprite and tile renderers. It sits directly upstream of every renderer: its `DrawX`, `DrawY` and `blank` drive renderer inputs, and `hs`/`vs` go to the VGA/HDMI output pins. Default timing is 640×480 at 60 Hz (800×525 total), one pixel per `vga_clk` cycle. It also supplies line/frame strobes and a frame counter for animation logic.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_wrap_counter.sv | 42 ++++
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the raster generator: 640x480@60 defaults and derived windows.
// Latency: n/a (constants and a pure compare helper only).
// Backpressure: n/a.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  // Default 640x480@60 timing, one pixel per clock
  localparam int unsigned H_VISIBLE_DEF   = 640;
  localparam int unsigned H_FRONT_DEF     = 16;
  localparam int unsigned H_SYNC_DEF      = 96;
  localparam int unsigned H_BACK_DEF      = 48;
  localparam int unsigned V_VISIBLE_DEF   = 480;
  localparam int unsigned V_FRONT_DEF     = 10;
  localparam int unsigned V_SYNC_DEF      = 2;
  localparam int unsigned V_BACK_DEF      = 33;
  localparam logic        SYNC_ACTIVE_DEF = 1'b0;
  localparam int unsigned FC_W_DEF        = 16;

  // Derived totals and sync windows for the default timing
  localparam int unsigned H_TOTAL_DEF  = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL_DEF  = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int unsigned HS_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
  localparam int unsigned VS_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

  // True when lo <= v < hi
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-(MAX+1) counter that advances on inc and exposes its next value for look-ahead decode.
// Latency: count updates one edge after inc; count_next and wrap are combinational.
// Backpressure: none; inc is a plain enable.
module vga_wrap_counter #(
  parameter int unsigned MAX = 799,
  parameter int unsigned W   = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;

  assign wrap       = inc && (r_count == MAX_V);
  assign count      = r_count;
  assign count_next = w_next;

  // Next value: reset wins, then wrap to zero, then increment
  always_comb begin
    w_next = r_count;
    if (reset) begin
      w_next = '0;
    end else if (wrap) begin
      w_next = '0;
    end else if (inc) begin
      w_next = r_count + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    r_count <= w_next;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, sync, visible-area and line/frame strobes.
// Latency: all outputs registered; strobes decoded from next-state coordinates so they align with DrawX/DrawY.
// Backpressure: none; free-running at one pixel per vga_clk.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT     = H_FRONT_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BACK      = H_BACK_DEF,
  parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT     = V_FRONT_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BACK      = V_BACK_DEF,
  parameter logic        SYNC_ACTIVE = SYNC_ACTIVE_DEF,
  parameter int unsigned FC_W        = FC_W_DEF
) (
  input  logic               vga_clk,
  input  logic               reset,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic               line_start,
  output logic               frame_start,
  output logic [FC_W-1:0]    frame_count
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Coordinates are COORD_W bits wide, so both totals must fit
  if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_total_too_big
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the coordinate width");
  end

  logic [COORD_W-1:0] w_x_next;
  logic [COORD_W-1:0] w_y_next;
  logic               w_h_wrap;
  logic               w_v_wrap;

  logic               r_hs;
  logic               r_vs;
  logic               r_blank;
  logic               r_line_start;
  logic               r_frame_start;
  logic [FC_W-1:0]    r_frame_count;

  vga_wrap_counter #(
    .MAX (H_TOTAL - 1),
    .W   (COORD_W)
  ) u_h_cnt (
    .clk        (vga_clk),
    .reset      (reset),
    .inc        (1'b1),
    .count      (DrawX),
    .count_next (w_x_next),
    .wrap       (w_h_wrap)
  );

  // Vertical advances once per completed line; its wrap marks end of frame
  vga_wrap_counter #(
    .MAX (V_TOTAL - 1),
    .W   (COORD_W)
  ) u_v_cnt (
    .clk        (vga_clk),
    .reset      (reset),
    .inc        (w_h_wrap),
    .count      (DrawY),
    .count_next (w_y_next),
    .wrap       (w_v_wrap)
  );

  // Strobes and frame counter, decoded from the coordinates being loaded this edge
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hs          <= ~SYNC_ACTIVE;
      r_vs          <= ~SYNC_ACTIVE;
      r_blank       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_hs          <= in_window(w_x_next, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vs          <= in_window(w_y_next, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_blank       <= (32'(w_x_next) < H_VISIBLE) && (32'(w_y_next) < V_VISIBLE);
      r_line_start  <= (w_x_next == '0);
      r_frame_start <= (w_x_next == '0) && (w_y_next == '0);
      if (w_v_wrap) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance A and small-timing instance B (14x7, active-high sync, 4-bit frame count).
// Every cycle a reference model pushes expected outputs to per-instance queues; they are popped and compared after the edge.
// Scenario tasks add targeted checks on line length, sync windows, frame-count wrap and mid-frame reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic [9:0]  a_x, a_y, b_x, b_y;
  logic        a_hs, a_vs, a_bl, a_ls, a_fs;
  logic        b_hs, b_vs, b_bl, b_ls, b_fs;
  logic [15:0] a_fc;
  logic [3:0]  b_fc;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state
  int ax = 0, ay = 0, afc = 0;
  int bx = 0, by = 0, bfc = 0;
  obs_t qa[$];
  obs_t qb[$];

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .vga_clk     (clk),
    .reset       (rst_a),
    .DrawX       (a_x),
    .DrawY       (a_y),
    .hs          (a_hs),
    .vs          (a_vs),
    .blank       (a_bl),
    .line_start  (a_ls),
    .frame_start (a_fs),
    .frame_count (a_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .SYNC_ACTIVE (1'b1), .FC_W (4)
  ) u_b (
    .vga_clk     (clk),
    .reset       (rst_b),
    .DrawX       (b_x),
    .DrawY       (b_y),
    .hs          (b_hs),
    .vs          (b_vs),
    .blank       (b_bl),
    .line_start  (b_ls),
    .frame_start (b_fs),
    .frame_count (b_fc)
  );

  function automatic obs_t model_out(input int x, input int y, input int fc,
                                     input int hv, input int hf, input int hsw,
                                     input int vv, input int vf, input int vsw,
                                     input bit sa, input bit rst);
    obs_t o;
    o = '0;
    if (rst) begin
      o.hs = ~sa;
      o.vs = ~sa;
    end else begin
      o.x     = 10'(x);
      o.y     = 10'(y);
      o.hs    = (x >= hv + hf && x < hv + hf + hsw) ? sa : ~sa;
      o.vs    = (y >= vv + vf && y < vv + vf + vsw) ? sa : ~sa;
      o.blank = (x < hv) && (y < vv);
      o.ls    = (x == 0);
      o.fs    = (x == 0) && (y == 0);
      o.fc    = 16'(fc);
    end
    return o;
  endfunction

  // One clock: drive resets, push model expectations, pop and compare after the edge
  task automatic step(input bit ra, input bit rb, output obs_t ga, output obs_t gb);
    obs_t ea, eb;
    rst_a = ra;
    rst_b = rb;
    if (ra) begin
      ax = 0; ay = 0; afc = 0;
    end else begin
      ax++;
      if (ax == 800) begin
        ax = 0; ay++;
        if (ay == 525) begin ay = 0; afc = (afc + 1) % 65536; end
      end
    end
    if (rb) begin
      bx = 0; by = 0; bfc = 0;
    end else begin
      bx++;
      if (bx == 14) begin
        bx = 0; by++;
        if (by == 7) begin by = 0; bfc = (bfc + 1) % 16; end
      end
    end
    qa.push_back(model_out(ax, ay, afc, 640, 16, 96, 480, 10, 2, 1'b0, ra));
    qb.push_back(model_out(bx, by, bfc, 8, 2, 2, 4, 1, 1, 1'b1, rb));
    @(posedge clk);
    #1;
    cyc++;
    ga = '{x: a_x, y: a_y, hs: a_hs, vs: a_vs, blank: a_bl, ls: a_ls, fs: a_fs, fc: a_fc};
    gb = '{x: b_x, y: b_y, hs: b_hs, vs: b_vs, blank: b_bl, ls: b_ls, fs: b_fs, fc: 16'(b_fc)};
    ea = qa.pop_front();
    eb = qb.pop_front();
    n_vec++;
    if (ga !== ea) begin
      n_bad++;
      $display("FAIL scoreboard_a cyc=%0d got x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d expected x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d",
               cyc, ga.x, ga.y, ga.hs, ga.vs, ga.blank, ga.ls, ga.fs, ga.fc,
               ea.x, ea.y, ea.hs, ea.vs, ea.blank, ea.ls, ea.fs, ea.fc);
    end
    n_vec++;
    if (gb !== eb) begin
      n_bad++;
      $display("FAIL scoreboard_b cyc=%0d got x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d expected x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d",
               cyc, gb.x, gb.y, gb.hs, gb.vs, gb.blank, gb.ls, gb.fs, gb.fc,
               eb.x, eb.y, eb.hs, eb.vs, eb.blank, eb.ls, eb.fs, eb.fc);
    end
  endtask

  task automatic test_reset();
    obs_t ga, gb;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, ga, gb);
      n_vec++;
      if (ga.x !== 10'd0 || ga.y !== 10'd0 || ga.blank !== 1'b0 || ga.hs !== 1'b1 ||
          ga.vs !== 1'b1 || ga.fc !== 16'd0) begin
        n_bad++;
        $display("FAIL reset_state_a got x=%0d y=%0d bl=%b hs=%b vs=%b fc=%0d expected 0 0 0 1 1 0",
                 ga.x, ga.y, ga.blank, ga.hs, ga.vs, ga.fc);
      end
    end
    step(1'b0, 1'b0, ga, gb);
    n_vec++;
    if (ga.x !== 10'd1 || ga.y !== 10'd0 || ga.blank !== 1'b1 || ga.fs !== 1'b0) begin
      n_bad++;
      $display("FAIL first_edge_a got x=%0d y=%0d bl=%b fs=%b expected x=1 y=0 bl=1 fs=0",
               ga.x, ga.y, ga.blank, ga.fs);
    end
  endtask

  // Instance A starts at (1,0); run to (0,2) and check line period and window widths
  task automatic test_line();
    obs_t ga, gb;
    int ls_n = 0, ls_first = -1, ls_last = -1, hs_low = 0, bl_hi = 0;
    for (int i = 0; i < 1599; i++) begin
      step(1'b0, 1'b0, ga, gb);
      if (ga.ls === 1'b1) begin
        ls_n++;
        if (ls_first < 0) ls_first = cyc;
        ls_last = cyc;
        n_vec++;
        if (ga.x !== 10'd0) begin
          n_bad++;
          $display("FAIL line_start_pos got x=%0d expected 0", ga.x);
        end
      end
      if (ga.hs === 1'b0) hs_low++;
      if (ga.blank === 1'b1) bl_hi++;
    end
    n_vec++;
    if (ls_n != 2 || (ls_last - ls_first) != 800) begin
      n_bad++;
      $display("FAIL line_period got pulses=%0d period=%0d expected pulses=2 period=800",
               ls_n, ls_last - ls_first);
    end
    n_vec++;
    if (hs_low != 192) begin
      n_bad++;
      $display("FAIL hsync_width got %0d expected 192", hs_low);
    end
    n_vec++;
    if (bl_hi != 1279) begin
      n_bad++;
      $display("FAIL visible_count got %0d expected 1279", bl_hi);
    end
  endtask

  // Instance B: count full frames, check vsync/visible per frame and the 15->0 counter wrap
  task automatic test_frame();
    obs_t ga, gb;
    int   fs_seen = 0, vs_hi = 0, bl_hi = 0, prev_fc = -1;
    bit   wrapped = 1'b0;
    for (int i = 0; i < 2000 && !wrapped; i++) begin
      step(1'b0, 1'b0, ga, gb);
      if (gb.fs === 1'b1) begin
        if (fs_seen == 1) begin
          n_vec++;
          if (vs_hi != 14 || bl_hi != 32) begin
            n_bad++;
            $display("FAIL frame_windows_b got vs_hi=%0d visible=%0d expected 14 32", vs_hi, bl_hi);
          end
        end
        fs_seen++;
        vs_hi = 0;
        bl_hi = 0;
      end
      if (gb.vs === 1'b1) vs_hi++;
      if (gb.blank === 1'b1) bl_hi++;
      if (prev_fc == 15 && gb.fc !== 16'd15) begin
        wrapped = 1'b1;
        n_vec++;
        if (gb.fc !== 16'd0 || gb.x !== 10'd0 || gb.y !== 10'd0 || gb.fs !== 1'b1) begin
          n_bad++;
          $display("FAIL fc_wrap_b got fc=%0d x=%0d y=%0d fs=%b expected fc=0 x=0 y=0 fs=1",
                   gb.fc, gb.x, gb.y, gb.fs);
        end
      end
      prev_fc = int'(gb.fc);
    end
    n_vec++;
    if (!wrapped) begin
      n_bad++;
      $display("FAIL fc_wrap_timeout got no wrap within 2000 cycles expected 15->0");
    end
  endtask

  // Mid-line/mid-frame reset pulses on each instance
  task automatic test_reset_mid();
    obs_t ga, gb;
    bit   hit = 1'b0;
    for (int i = 0; i < 900 && !hit; i++) begin
      step(1'b0, 1'b0, ga, gb);
      if (ga.x === 10'd700) hit = 1'b1;
    end
    n_vec++;
    if (!hit) begin
      n_bad++;
      $display("FAIL reach_700_timeout got x=%0d expected 700", ga.x);
    end
    step(1'b1, 1'b0, ga, gb);
    n_vec++;
    if (ga.x !== 10'd0 || ga.y !== 10'd0 || ga.hs !== 1'b1 || ga.blank !== 1'b0 || ga.fc !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_reset_a got x=%0d y=%0d hs=%b bl=%b fc=%0d expected 0 0 1 0 0",
               ga.x, ga.y, ga.hs, ga.blank, ga.fc);
    end
    step(1'b0, 1'b0, ga, gb);
    n_vec++;
    if (ga.x !== 10'd1 || ga.y !== 10'd0) begin
      n_bad++;
      $display("FAIL resume_a got x=%0d y=%0d expected 1 0", ga.x, ga.y);
    end
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step(1'b0, 1'b0, ga, gb);
      if (gb.x === 10'd10 && gb.y === 10'd5) hit = 1'b1;
    end
    n_vec++;
    if (!hit || gb.hs !== 1'b1 || gb.vs !== 1'b1) begin
      n_bad++;
      $display("FAIL sync_corner_b got x=%0d y=%0d hs=%b vs=%b expected x=10 y=5 hs=1 vs=1",
               gb.x, gb.y, gb.hs, gb.vs);
    end
    step(1'b0, 1'b1, ga, gb);
    n_vec++;
    if (gb.x !== 10'd0 || gb.y !== 10'd0 || gb.hs !== 1'b0 || gb.vs !== 1'b0 || gb.fc !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_reset_b got x=%0d y=%0d hs=%b vs=%b fc=%0d expected 0 0 0 0 0",
               gb.x, gb.y, gb.hs, gb.vs, gb.fc);
    end
    for (int i = 0; i < 120; i++) step(1'b0, 1'b0, ga, gb);
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
